// File: rtl/hazard_stall_ctrl_if.sv
// Control bundle between the decoded pipeline stages and the hazard/stall sequencer.
// master = pipeline side (drives decoded control), slave = sequencer side.
interface hazard_stall_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic            ID_Valid;
  logic [RA_W-1:0] ID_Rs;
  logic [RA_W-1:0] ID_Rt;
  logic            ID_Jump;
  logic            EX_MemRead;
  logic [RA_W-1:0] EX_Rt;
  logic            EX_IsMul;
  logic            MEM_BrTaken;

  logic             PC_Write;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Write;
  logic             IDEX_Bubble;
  logic             EXMEM_Bubble;
  logic [1:0]       Stall_Cause;
  logic [CNT_W-1:0] Stall_Cycles;

  modport master (
    output ID_Valid, ID_Rs, ID_Rt, ID_Jump, EX_MemRead, EX_Rt, EX_IsMul, MEM_BrTaken,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble,
           Stall_Cause, Stall_Cycles
  );

  modport slave (
    input  ID_Valid, ID_Rs, ID_Rt, ID_Jump, EX_MemRead, EX_Rt, EX_IsMul, MEM_BrTaken,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble,
           Stall_Cause, Stall_Cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use stall, multi-cycle MUL hold,
// taken-branch and jump flushes. RA_W/CNT_W must match the connected interface instance.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16
) (
  input  logic Clk,
  input  logic Rst,
  hazard_stall_ctrl_if.slave hz
);

    localparam int MCW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [MCW-1:0] MUL_INIT = MCW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam bit MUL_STALLS = (MUL_LAT > 1);

    typedef enum logic {RUN, MUL_BUSY} state_t;

    state_t           state;
    logic [MCW-1:0]   mul_cnt;
    logic [CNT_W-1:0] stall_cnt;

    logic [RA_W-1:0] ex_rt;
    logic            load_use;
    logic            mul_enter;
    logic            mul_hold;

    logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble;
    logic [1:0] cause;

    assign ex_rt    = hz.EX_Rt;
    assign load_use = (state == RUN) && hz.EX_MemRead && (ex_rt != '0) && hz.ID_Valid &&
                      ((ex_rt == hz.ID_Rs) || (ex_rt == hz.ID_Rt));
    assign mul_enter = (state == RUN) && hz.EX_IsMul && MUL_STALLS;
    // The final MUL_BUSY cycle (mul_cnt==0) releases the pipeline so EX/MEM captures the result.
    assign mul_hold  = mul_enter || ((state == MUL_BUSY) && (mul_cnt != '0));

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        cause        = 2'd0;
        if (!Rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_write   = 1'b0;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else if (hz.MEM_BrTaken) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            cause        = 2'd3;
        end else if (mul_hold) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            cause        = 2'd2;
        end else if (load_use) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            cause        = 2'd1;
        end else if (hz.ID_Jump && hz.ID_Valid) begin
            ifid_flush   = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= RUN;
            mul_cnt <= '0;
        end else if (hz.MEM_BrTaken) begin
            state   <= RUN;
            mul_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mul_enter) begin
                        state   <= MUL_BUSY;
                        mul_cnt <= MUL_INIT;
                    end
                end
                MUL_BUSY: begin
                    if (mul_cnt == '0) state <= RUN;
                    else               mul_cnt <= mul_cnt - MCW'(1);
                end
                default: begin
                    state   <= RUN;
                    mul_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)                              stall_cnt <= '0;
        else if (!pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign hz.PC_Write     = pc_write;
    assign hz.IFID_Write   = ifid_write;
    assign hz.IFID_Flush   = ifid_flush;
    assign hz.IDEX_Write   = idex_write;
    assign hz.IDEX_Bubble  = idex_bubble;
    assign hz.EXMEM_Bubble = exmem_bubble;
    assign hz.Stall_Cause  = cause;
    assign hz.Stall_Cycles = stall_cnt;

endmodule
